// File: rtl/microseq_pkg.sv
// Shared definitions for the microcode sequencer: sequencing opcodes, FSM states,
// and microword layout helpers (ctrl | seq_op | cond_sel | next_addr, MSB to LSB).
package microseq_pkg;

  localparam logic [2:0] SEQ_NEXT     = 3'd0;
  localparam logic [2:0] SEQ_JUMP     = 3'd1;
  localparam logic [2:0] SEQ_BRT      = 3'd2;
  localparam logic [2:0] SEQ_BRF      = 3'd3;
  localparam logic [2:0] SEQ_DISPATCH = 3'd4;
  localparam logic [2:0] SEQ_CALL     = 3'd5;
  localparam logic [2:0] SEQ_RET      = 3'd6;
  localparam logic [2:0] SEQ_WAIT     = 3'd7;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  function automatic int cond_sel_w(input int num_cond);
    return (num_cond <= 2) ? 1 : $clog2(num_cond);
  endfunction

  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int word_w(input int addr_w, input int ctrl_w, input int num_cond);
    return ctrl_w + 3 + cond_sel_w(num_cond) + addr_w;
  endfunction

  function automatic int csel_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int op_lsb(input int addr_w, input int num_cond);
    return addr_w + cond_sel_w(num_cond);
  endfunction

  function automatic int ctrl_lsb(input int addr_w, input int num_cond);
    return addr_w + cond_sel_w(num_cond) + 3;
  endfunction

endpackage

// File: rtl/microseq_store_if.sv
// Decoder/datapath-facing bundle of the micro-sequencer; write-patch signals exist
// only when MICROSEQ_WRITE_EN is defined.
interface microseq_store_if
  import microseq_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int CTRL_W      = 31,
  parameter int NUM_COND    = 4,
  parameter int STACK_DEPTH = 4
);
  logic                              restart;
  logic                              stall;
  logic [NUM_COND-1:0]               cond;
  logic [ADDR_W-1:0]                 dispatch_addr;
  logic [CTRL_W-1:0]                 cs;
  logic                              cs_valid;
  logic [ADDR_W-1:0]                 upc;
  logic [level_w(STACK_DEPTH)-1:0]   stack_level;
  logic                              fault;
`ifdef MICROSEQ_WRITE_EN
  logic                                           wr_en;
  logic [ADDR_W-1:0]                              wr_addr;
  logic [word_w(ADDR_W, CTRL_W, NUM_COND)-1:0]    wr_data;
`endif

  modport master (
`ifdef MICROSEQ_WRITE_EN
    output wr_en, wr_addr, wr_data,
`endif
    output restart, stall, cond, dispatch_addr,
    input  cs, cs_valid, upc, stack_level, fault
  );

  modport slave (
`ifdef MICROSEQ_WRITE_EN
    input  wr_en, wr_addr, wr_data,
`endif
    input  restart, stall, cond, dispatch_addr,
    output cs, cs_valid, upc, stack_level, fault
  );
endinterface

// File: rtl/microseq_stack.sv
// Return-address LIFO; push is ignored when full and pop when empty, so the caller
// can detect overflow/underflow from full/empty before committing.
module microseq_stack
  import microseq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 5,
  parameter int LVL_W = level_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     top,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [LVL_W-1:0] lvl;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign wr_ptr  = PTR_W'(lvl);
  assign rd_ptr  = wr_ptr - PTR_W'(1);
  assign full    = (lvl == LVL_W'(DEPTH));
  assign empty   = (lvl == '0);
  assign level   = lvl;
  assign top     = mem[rd_ptr];
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          lvl <= '0;
    else if (clr)     lvl <= '0;
    else if (do_push) lvl <= lvl + LVL_W'(1);
    else if (do_pop)  lvl <= lvl - LVL_W'(1);
  end

  // Entries need no reset: only the level says which ones are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/microseq_store.sv
// Microcode store with registered micro-PC sequencer and hardware return stack.
// Define MICROSEQ_WRITE_EN to add the in-field microcode write port.
module microseq_store
  import microseq_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int CTRL_W      = 31,
  parameter int NUM_COND    = 4,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0,
  parameter     INIT_FILE   = "",
  parameter logic [word_w(ADDR_W, CTRL_W, NUM_COND)-1:0] DEFAULT_WORD = '0
) (
  input logic             clk,
  input logic             rst,
  microseq_store_if.slave bus
);
  localparam int CSW    = cond_sel_w(NUM_COND);
  localparam int WORD_W = word_w(ADDR_W, CTRL_W, NUM_COND);
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int LVL_W  = level_w(STACK_DEPTH);
  localparam int CSEL_L = csel_lsb(ADDR_W);
  localparam int OP_L   = op_lsb(ADDR_W, NUM_COND);
  localparam int CTRL_L = ctrl_lsb(ADDR_W, NUM_COND);
  localparam logic [ADDR_W-1:0] RST_A = ADDR_W'(RESET_ADDR);

  logic [WORD_W-1:0] mem [DEPTH] = '{default: DEFAULT_WORD};

`ifdef MICROSEQ_WRITE_EN
  always_ff @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
  end
`endif

  state_t            state;
  logic [ADDR_W-1:0] upc, upc_inc, nxt, fetch_addr, tgt, stk_top;
  logic [CTRL_W-1:0] cs, fetch_ctrl;
  logic [2:0]        op;
  logic [CSW-1:0]    csel;
  logic              cs_valid, fault, hit, run, push, pop, bad;
  logic              stk_full, stk_empty;
  logic [LVL_W-1:0]  stk_level;

  assign op      = mem[upc][OP_L +: 3];
  assign csel    = mem[upc][CSEL_L +: CSW];
  assign tgt     = mem[upc][ADDR_W-1:0];
  assign upc_inc = upc + ADDR_W'(1);
  assign hit     = (int'(csel) < NUM_COND) && bus.cond[csel];
  assign run     = (state == ST_RUN) && !bus.stall && !bus.restart;

  always_comb begin
    nxt  = upc_inc;
    push = 1'b0;
    pop  = 1'b0;
    bad  = 1'b0;
    case (op)
      SEQ_JUMP:     nxt = tgt;
      SEQ_BRT:      if (hit) nxt = tgt;
      SEQ_BRF:      if (!hit) nxt = tgt;
      SEQ_DISPATCH: nxt = bus.dispatch_addr;
      SEQ_CALL:     if (stk_full) bad = 1'b1;
                    else begin push = run; nxt = tgt; end
      SEQ_RET:      if (stk_empty) bad = 1'b1;
                    else begin pop = run; nxt = stk_top; end
      SEQ_WAIT:     if (!hit) nxt = upc;
      default:      ;
    endcase
  end

  // One read port serves every fetch: restart/BOOT fetch RESET_ADDR, RUN fetches nxt.
  assign fetch_addr = (bus.restart || state == ST_BOOT) ? RST_A : nxt;

  always_comb begin
    fetch_ctrl = mem[fetch_addr][CTRL_L +: CTRL_W];
`ifdef MICROSEQ_WRITE_EN
    if (bus.wr_en && bus.wr_addr == fetch_addr) fetch_ctrl = bus.wr_data[CTRL_L +: CTRL_W];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_BOOT;
      upc      <= RST_A;
      cs       <= '0;
      cs_valid <= 1'b0;
      fault    <= 1'b0;
    end else if (bus.restart) begin
      state    <= ST_RUN;
      upc      <= RST_A;
      cs       <= fetch_ctrl;
      cs_valid <= 1'b1;
      fault    <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state    <= ST_RUN;
          cs       <= fetch_ctrl;
          cs_valid <= 1'b1;
        end
        ST_RUN: if (!bus.stall) begin
          if (bad) begin
            state    <= ST_FAULT;
            fault    <= 1'b1;
            cs       <= '0;
            cs_valid <= 1'b0;
          end else begin
            upc <= nxt;
            cs  <= fetch_ctrl;
          end
        end
        default: ;
      endcase
    end
  end

  microseq_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W), .LVL_W(LVL_W)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.restart),
    .push  (push),
    .pop   (pop),
    .din   (upc_inc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty),
    .level (stk_level)
  );

  assign bus.cs          = cs;
  assign bus.cs_valid    = cs_valid;
  assign bus.upc         = upc;
  assign bus.stack_level = stk_level;
  assign bus.fault       = fault;
endmodule
